// File: rtl/torus_pkg.sv
// torus_pkg: flit width, port ids and dimension-order routing helper shared by the torus mesh
package torus_pkg;
  localparam int FLIT_DATA_WIDTH = 32;
  localparam int VC_MSB = FLIT_DATA_WIDTH - 1;
  localparam int NUM_PORTS = 5;
  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, EAST, WEST} port_e;
  // X first, then Y; equal distance either way resolves to East/South
  function automatic port_e route_dir(input int own, input int dst, input int rows, input int cols);
    int de, ds;
    de = (dst % cols - own % cols + cols) % cols;
    ds = (dst / cols - own / cols + rows) % rows;
    return de != 0 ? (2 * de <= cols ? EAST : WEST) : ds != 0 ? (2 * ds <= rows ? SOUTH : NORTH) : LOCAL;
  endfunction
endpackage

// File: rtl/torus_router.sv
// torus_router: 5-port router with one flit slot per input VC, per-output round-robin switch
// and dateline VC MSB handling on wrap links and X->Y turns.
module torus_router
  import torus_pkg::*;
#(
  parameter int ROUTER_ID = 0,
  parameter int ROW_COUNT = 5,
  parameter int COL_COUNT = 5,
  parameter int NUM_VC    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_inj_valid,
  input  logic [FLIT_DATA_WIDTH-1:0]        i_inj_data,
  input  logic [4:1]                        i_in_valid,
  input  logic [4:1][FLIT_DATA_WIDTH-1:0]   i_in_data,
  input  logic [4:1][NUM_VC-1:0]            i_ds_occ,
  output logic [4:1]                        o_out_valid,
  output logic [4:1][FLIT_DATA_WIDTH-1:0]   o_out_data,
  output logic [4:1][NUM_VC-1:0]            o_occ,
  output logic                              o_ej_valid,
  output logic [FLIT_DATA_WIDTH-1:0]        o_ej_data
);
  localparam int N = ROW_COUNT * COL_COUNT;
  localparam int VB = $clog2(NUM_VC);
  localparam int IB = $clog2(N);
  localparam int DLSB = VC_MSB + 1 - VB - IB;
  localparam int S = NUM_PORTS * NUM_VC;
  localparam int PW = $clog2(S);
  localparam int ROW = ROUTER_ID / COL_COUNT;
  localparam int COL = ROUTER_ID % COL_COUNT;
  localparam logic [FLIT_DATA_WIDTH-1:0] MSB_CLR = {1'b0, {VC_MSB{1'b1}}};

  logic [FLIT_DATA_WIDTH-1:0] r_fifo [4];
  logic [1:0] r_rp, r_wp;
  logic [2:0] r_cnt;
  logic [S-1:0] r_sv;
  logic [FLIT_DATA_WIDTH-1:0] r_sd [S];
  logic [PW-1:0] r_ptr [NUM_PORTS];
  logic r_ej_valid;
  logic [FLIT_DATA_WIDTH-1:0] r_ej_data;

  port_e w_dir [S];
  logic [FLIT_DATA_WIDTH-1:0] w_nf [S];
  logic [FLIT_DATA_WIDTH-1:0] w_sin [S];
  logic [4:0][NUM_VC-1:0] w_occ_all;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [PW-1:0] w_win [NUM_PORTS];
  logic [S-1:0] w_take, w_set;
  logic [FLIT_DATA_WIDTH-1:0] w_head;
  logic [VB-1:0] w_hvc;
  logic w_push, w_pop;

  assign w_head = r_fifo[r_rp] & MSB_CLR;
  assign w_hvc = w_head[VC_MSB -: VB];
  assign w_push = i_inj_valid && int'(i_inj_data[DLSB +: IB]) < N && r_cnt != 3'd4;
  assign w_pop = r_cnt != 3'd0 && !r_sv[w_hvc];
  assign o_ej_valid = r_ej_valid;
  assign o_ej_data = r_ej_data;

  // Outgoing flit: wrap link sets the VC MSB, an X->Y turn clears it first
  always_comb begin
    for (int s = 0; s < S; s++) begin
      w_dir[s] = route_dir(ROUTER_ID, int'(r_sd[s][DLSB +: IB]), ROW_COUNT, COL_COUNT);
      w_nf[s] = r_sd[s];
      w_nf[s][VC_MSB] = (w_dir[s] == EAST && COL == COL_COUNT - 1) || (w_dir[s] == WEST && COL == 0) ||
        (w_dir[s] == SOUTH && ROW == ROW_COUNT - 1) || (w_dir[s] == NORTH && ROW == 0) ||
        (r_sd[s][VC_MSB] && !((w_dir[s] == NORTH || w_dir[s] == SOUTH) &&
          s / NUM_VC != int'(NORTH) && s / NUM_VC != int'(SOUTH)));
    end
  end

  // Ejection never back-pressures, so its occupancy row is all zeros
  always_comb begin
    int k;
    k = 0;
    w_occ_all = {i_ds_occ, NUM_VC'(0)};
    w_take = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_gnt[o] = 1'b0;
      w_win[o] = '0;
      for (int i = 0; i < S; i++) begin
        k = (int'(r_ptr[o]) + i) % S;
        if (!w_gnt[o] && r_sv[k] && int'(w_dir[k]) == o && !w_occ_all[o][w_nf[k][VC_MSB -: VB]]) begin
          w_gnt[o] = 1'b1;
          w_win[o] = PW'(k);
          w_take[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < S; s++) begin
      w_set[s] = 1'b0;
      w_sin[s] = w_head;
    end
    w_set[w_hvc] = w_pop;
    for (int p = 1; p < NUM_PORTS; p++)
      for (int v = 0; v < NUM_VC; v++) begin
        w_set[p*NUM_VC+v] = i_in_valid[p] && int'(i_in_data[p][VC_MSB -: VB]) == v;
        w_sin[p*NUM_VC+v] = i_in_data[p];
      end
  end

  always_comb begin
    for (int o = 1; o < NUM_PORTS; o++) begin
      o_out_valid[o] = w_gnt[o];
      o_out_data[o] = w_nf[w_win[o]];
      o_occ[o] = r_sv[o*NUM_VC +: NUM_VC];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sv <= '0;
      r_rp <= '0;
      r_wp <= '0;
      r_cnt <= '0;
      r_ej_valid <= 1'b0;
      r_ej_data <= '0;
      for (int o = 0; o < NUM_PORTS; o++) r_ptr[o] <= '0;
    end else begin
      r_sv <= (r_sv & ~w_take) | w_set;
      r_rp <= r_rp + 2'(w_pop);
      r_wp <= r_wp + 2'(w_push);
      r_cnt <= r_cnt + 3'(w_push) - 3'(w_pop);
      r_ej_valid <= w_gnt[LOCAL];
      r_ej_data <= w_gnt[LOCAL] ? r_sd[w_win[LOCAL]] : '0;
      for (int o = 0; o < NUM_PORTS; o++)
        if (w_gnt[o]) r_ptr[o] <= w_win[o] == PW'(S - 1) ? '0 : w_win[o] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= i_inj_data;
    for (int s = 0; s < S; s++)
      if (w_set[s]) r_sd[s] <= w_sin[s];
  end
endmodule

// File: rtl/torus_topology.sv
// torus_topology: ROW_COUNT x COL_COUNT torus of torus_router instances joined by wraparound links.
module torus_topology
  import torus_pkg::*;
#(
  parameter int ROW_COUNT = 5,
  parameter int COL_COUNT = 5,
  parameter int NUM_VC    = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [ROW_COUNT*COL_COUNT-1:0]         nic_output_valid,
  input  logic [FLIT_DATA_WIDTH-1:0]             nic_output_data [ROW_COUNT*COL_COUNT],
  output logic [ROW_COUNT*COL_COUNT-1:0]         nic_input_valid,
  output logic [FLIT_DATA_WIDTH-1:0]             nic_input_data [ROW_COUNT*COL_COUNT]
);
  localparam int N = ROW_COUNT * COL_COUNT;

  logic [4:1] w_out_valid [N];
  logic [4:1] w_in_valid [N];
  logic [4:1][FLIT_DATA_WIDTH-1:0] w_out_data [N];
  logic [4:1][FLIT_DATA_WIDTH-1:0] w_in_data [N];
  logic [4:1][NUM_VC-1:0] w_occ [N];
  logic [4:1][NUM_VC-1:0] w_ds_occ [N];

  // Each input port faces the neighbour's opposite output; the same pairing carries occupancy back
  for (genvar g = 0; g < N; g++) begin : g_rt
    localparam int R = g / COL_COUNT;
    localparam int C = g % COL_COUNT;
    localparam int NB = ((R + ROW_COUNT - 1) % ROW_COUNT) * COL_COUNT + C;
    localparam int SB = ((R + 1) % ROW_COUNT) * COL_COUNT + C;
    localparam int EB = R * COL_COUNT + (C + 1) % COL_COUNT;
    localparam int WB = R * COL_COUNT + (C + COL_COUNT - 1) % COL_COUNT;
    assign w_in_valid[g] = {w_out_valid[WB][EAST], w_out_valid[EB][WEST], w_out_valid[SB][NORTH], w_out_valid[NB][SOUTH]};
    assign w_in_data[g] = {w_out_data[WB][EAST], w_out_data[EB][WEST], w_out_data[SB][NORTH], w_out_data[NB][SOUTH]};
    assign w_ds_occ[g] = {w_occ[WB][EAST], w_occ[EB][WEST], w_occ[SB][NORTH], w_occ[NB][SOUTH]};
    torus_router #(
      .ROUTER_ID(g),
      .ROW_COUNT(ROW_COUNT),
      .COL_COUNT(COL_COUNT),
      .NUM_VC(NUM_VC)
    ) u_router (
      .clk(clk),
      .rst_n(reset),
      .i_inj_valid(nic_output_valid[g]),
      .i_inj_data(nic_output_data[g]),
      .i_in_valid(w_in_valid[g]),
      .i_in_data(w_in_data[g]),
      .i_ds_occ(w_ds_occ[g]),
      .o_out_valid(w_out_valid[g]),
      .o_out_data(w_out_data[g]),
      .o_occ(w_occ[g]),
      .o_ej_valid(nic_input_valid[g]),
      .o_ej_data(nic_input_data[g])
    );
  end
endmodule

// File: tb/tb_torus_topology.sv
// tb_torus_topology: directed torus traffic with a scoreboard queue checked by an ejection monitor.
module tb_torus_topology;
  localparam int R = 5, C = 5, V = 4, N = R * C;
  localparam logic [31:0] FULL = 32'hFFFF_FFFF, NOVC = 32'h3FFF_FFFF;

  typedef struct {
    int r;
    logic [31:0] d;
    logic [31:0] m;
    int lo;
    int hi;
  } exp_t;

  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] nov = '0, niv;
  logic [31:0] nod [N];
  logic [31:0] nid [N];
  exp_t sb[$];
  int cyc = 0, n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  torus_topology #(.ROW_COUNT(R), .COL_COUNT(C), .NUM_VC(V)) dut (
    .clk(clk),
    .reset(reset),
    .nic_output_valid(nov),
    .nic_output_data(nod),
    .nic_input_valid(niv),
    .nic_input_data(nid)
  );

  function automatic logic [31:0] flit(int vc, int dst, int pay);
    return (32'(vc) << 30) | (32'(dst) << 25) | 32'(pay & 'h1FF_FFFF);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called just after a posedge; the flit is sampled at the next edge (cyc + 1)
  task automatic send(int src, logic [31:0] d, int dst, logic [31:0] e, logic [31:0] m, int lo, int hi);
    nov[src] = 1'b1;
    nod[src] = d;
    if (dst >= 0) sb.push_back('{dst, e, m, cyc + 1 + lo, cyc + 1 + hi});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    nov = '0;
  endtask

  task automatic drain(int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain_outstanding", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    int k;
    logic z;
    k = -1;
    z = 1'b1;
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        if (!niv[r]) z &= nid[r] == 32'd0;
        else begin
          k = -1;
          foreach (sb[i]) if (k < 0 && sb[i].r == r && ((nid[r] ^ sb[i].d) & sb[i].m) == 32'd0) k = i;
          n_chk++;
          if (k < 0) begin
            n_fail++;
            $display("FAIL eject_r%0d: got unexpected flit %h at cycle %0d, required none", r, nid[r], cyc);
          end else begin
            if (cyc < sb[k].lo || cyc > sb[k].hi) begin
              n_fail++;
              $display("FAIL latency_r%0d: got cycle %0d, required %0d..%0d", r, cyc, sb[k].lo, sb[k].hi);
            end
            sb.delete(k);
          end
        end
      end
      n_chk++;
      if (!z) begin
        n_fail++;
        $display("FAIL idle_data: got nonzero data on a non-valid port at cycle %0d, required 0", cyc);
      end
    end
  end

  initial begin
    logic [31:0] acc;
    foreach (nod[i]) nod[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(niv), 64'd0);
    @(negedge clk) reset = 1'b1;
    repeat (10) tick;
    check("idle_valid", 64'(niv), 64'd0);

    send(7, flit(0, 7, 'h055), 7, flit(0, 7, 'h055), FULL, 2, 2);
    tick;
    drain(20);
    send(7, flit(3, 7, 'h0AA), 7, flit(1, 7, 'h0AA), FULL, 2, 2);
    tick;
    drain(20);
    send(0, flit(0, 4, 'h0A4), 4, flit(2, 4, 'h0A4), FULL, 3, 3);
    tick;
    drain(20);
    send(0, flit(1, 12, 'h12C), 12, flit(1, 12, 'h12C), FULL, 6, 6);
    tick;
    drain(20);
    send(24, flit(0, 0, 'h240), 0, flit(2, 0, 'h240), FULL, 4, 4);
    tick;
    drain(20);
    send(1, flit(0, 0, 'h011), 0, flit(0, 0, 'h011), FULL, 3, 4);
    send(5, flit(0, 0, 'h051), 0, flit(0, 0, 'h051), FULL, 3, 4);
    tick;
    drain(20);
    send(3, flit(0, 27, 'h005), -1, '0, '0, 0, 0);
    tick;
    drain(20);

    for (int j = 0; j < N; j++) begin
      send(j, flit(0, (7 * j + 3) % N, 'h100 + j), (7 * j + 3) % N, flit(0, (7 * j + 3) % N, 'h100 + j), NOVC, 2, 100);
      tick;
    end
    drain(150);

    send(0, flit(0, 12, 'h077), -1, '0, '0, 0, 0);
    tick;
    tick;
    #2 reset = 1'b0;
    #1;
    acc = '0;
    foreach (nid[i]) acc |= nid[i];
    check("async_reset_valid", 64'(niv), 64'd0);
    check("async_reset_data", 64'(acc), 64'd0);
    sb.delete();
    @(negedge clk) reset = 1'b1;
    repeat (12) tick;
    send(7, flit(0, 7, 'h3C3), 7, flit(0, 7, 'h3C3), FULL, 2, 2);
    tick;
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/torus_topology.md
TORUS_TOPOLOGY -- requirements
Module: torus_topology

Interface
REQ-001 Param ROW_COUNT, default 5, mesh rows (>=2).
REQ-002 Param COL_COUNT, default 5, mesh columns (>=2).
REQ-003 Param NUM_VC, default 4, virtual channels per input port (even, >=2).
REQ-004 clk  input  1  sole clock, all state on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 nic_output_valid  input  [N-1:0]  per-router NIC injection valid, N=ROW_COUNT*COL_COUNT.
REQ-007 nic_output_data  input  [FLIT_DATA_WIDTH-1:0] x N unpacked  injected flit per router.
REQ-008 nic_input_valid  output  [N-1:0]  per-router ejection valid.
REQ-009 nic_input_data  output  [FLIT_DATA_WIDTH-1:0] x N unpacked  ejected flit per router.

Function
REQ-010 Flit fields: top VC_BITS=clog2(NUM_VC) bits = VC id; next ROUTER_ID_BITS=clog2(N) bits = destination router; remaining low bits = payload, carried unchanged.
REQ-011 Router id = row*COL_COUNT+col; East = col+1 mod COL_COUNT, South = row+1 mod ROW_COUNT; edge links wrap.
REQ-012 Each router: 5 ports (Local, N, S, E, W); each input port holds one flit register per VC.
REQ-013 Injection: valid flit sampled at posedge into a 4-deep per-router injection FIFO; FIFO head moves to Local input VC slot (VC = injected VC with MSB cleared) when that slot is empty; flit dropped if FIFO full or dest >= N.
REQ-014 Routing: dimension order, X (column) first then Y; shortest torus direction; tie on equal distance chooses East/South; dest == own id requests ejection.
REQ-015 Dateline: VC MSB cleared on entering network and on turning X->Y; set on traversing any wrap link; VC low bits preserved.
REQ-016 Flow control: flit may advance only into a downstream VC slot that is empty at start of cycle (registered occupancy); a slot drained this cycle accepts no new flit until next cycle; no combinational paths between routers.
REQ-017 Switch: per output port (incl. ejection) round-robin arbiter over all 5*NUM_VC input slots; at most one flit per output per cycle; pointer advances past winner.
REQ-018 One hop per cycle: flit in a slot at edge k occupies neighbor slot at edge k+1 if granted.
REQ-019 Ejection registered: nic_input_valid high exactly one cycle per flit; nic_input_data = flit with VC field of last slot; nic_input_data=0 when not valid.
REQ-020 Uncontended latency: H hops -> nic_input_valid high H+2 cycles after sampling edge (H=0 -> 2 cycles, including FIFO stage).
REQ-021 No flit is duplicated or reordered within the same source/dest/VC pair.

Reset
REQ-022 While reset low: all FIFOs and slots empty, arbiter pointers 0, nic_input_valid=0, nic_input_data=0, asynchronously.
REQ-023 Reset asserted mid-operation discards all in-flight flits; no ejection in the cycle after release.

Structure
REQ-024 FLIT_DATA_WIDTH=32 defined in shared header VR_define.vh; package torus_pkg holds port enum (LOCAL,NORTH,SOUTH,EAST,WEST) and field-position constants.
REQ-025 One sub-module torus_router (params ROUTER_ID, ROW_COUNT, COL_COUNT, NUM_VC); torus_topology only instantiates N routers in a generate loop and wires wrap links.

Verification (5x5, NUM_VC=4, VC [31:30], dest [29:25])
REQ-026 Reset then 10 idle cycles -> all nic_input_valid 0.
REQ-027 Router 7 injects dest 7, payload 0x055 -> router 7 valid 2 cycles later, data[11:0]=0x055.
REQ-028 Router 0 injects dest 4 -> one West wrap hop, router 4 valid 3 cycles later, VC[31]=1.
REQ-029 Router 0 injects dest 12 -> 4 hops, router 12 valid 6 cycles later, payload intact.
REQ-030 Routers 1 and 5 inject dest 0 same cycle -> both ejected at router 0 on distinct cycles, none lost.
REQ-031 Each router j injects one flit on consecutive cycles, random dest, unique 11-bit ID -> within 100 cycles all 25 ejected exactly once at correct router.
